// File: rtl/ped_pkg.sv
// ped_pkg: constants and types shared by the pedestrian request front end.
//   LIGHT_RED / LIGHT_YELLOW / LIGHT_GREEN : one-hot pedestrian light codes,
//                                            identical to the crossing controller's.
//   ped_state_t                            : request FSM states.
//   is_green()                             : exact GREEN decode. Multi-hot codes are not GREEN.
package ped_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WALK    = 2'd2,
        HOLDOFF = 2'd3
    } ped_state_t;

    function automatic logic is_green(input logic [2:0] light);
        return (light == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/ped_request_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser, debounce counter and rising-edge pulse
// for the raw pedestrian push button.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   din   : raw, asynchronous, possibly bouncing pad input
//   level : debounced button level
//   press : one-cycle pulse on a rising edge of level
// A level change is accepted only after the synchronised input has differed
// from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter on the pad
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // stage p1 -> debounced level
            level_d <= level;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian-side requester for the crossing controller.
// Debounces the push button, raises and holds ped_btn until WALK is granted,
// drives the WAIT lamp and WALK countdown, and enforces a minimum gap
// between pedestrian phases.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   btn_raw    : raw push-button pad (asynchronous, bouncing)
//   ped_light  : pedestrian light from controller (RED=100, YELLOW=010, GREEN=001)
//   ped_btn    : registered request level to the controller
//   wait_lamp  : registered WAIT lamp, lit while a request is outstanding or pending
//   walk_count : registered WALK countdown, 0 outside WALK
module ped_request_ctrl
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 4,
    parameter int MIN_GAP_CYCLES  = 8,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic [2:0]       ped_light,
    output logic             ped_btn,
    output logic             wait_lamp,
    output logic [CNT_W-1:0] walk_count
);

    logic btn_level;
    logic btn_press;
    logic press;
    logic green;

    ped_state_t       state,      state_nxt;
    logic             pending,    pending_nxt;
    logic [CNT_W-1:0] gap,        gap_nxt;
    logic [CNT_W-1:0] walk_count_nxt;
    logic             ped_btn_nxt;
    logic             wait_lamp_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (btn_raw),
        .level (btn_level),
        .press (btn_press)
    );

    // A press pulse always coincides with a high debounced level; gating on
    // it keeps the request qualified by the accepted button state.
    assign press = btn_press & btn_level;
    assign green = is_green(ped_light);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            gap        <= '0;
            walk_count <= '0;
            ped_btn    <= 1'b0;
            wait_lamp  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            gap        <= gap_nxt;
            walk_count <= walk_count_nxt;
            ped_btn    <= ped_btn_nxt;
            wait_lamp  <= wait_lamp_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        gap_nxt        = gap;
        walk_count_nxt = walk_count;

        unique case (state)
            IDLE: begin
                // GREEN without a request of ours is not our phase.
                if (press) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (green) begin
                    state_nxt      = WALK;
                    walk_count_nxt = CNT_W'(WALK_CYCLES);
                end
            end
            WALK: begin
                if (press) begin
                    pending_nxt = 1'b1;
                end
                if (!green) begin
                    state_nxt      = HOLDOFF;
                    gap_nxt        = CNT_W'(MIN_GAP_CYCLES);
                    walk_count_nxt = '0;
                end else if (walk_count != '0) begin
                    walk_count_nxt = walk_count - CNT_W'(1);
                end
            end
            HOLDOFF: begin
                gap_nxt = gap - CNT_W'(1);
                if (gap == CNT_W'(1)) begin
                    // A press landing on the expiry edge still counts as pending.
                    if (pending || press) begin
                        state_nxt   = REQ;
                        pending_nxt = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (press) begin
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Moore outputs registered from the next state.
        ped_btn_nxt   = (state_nxt == REQ);
        wait_lamp_nxt = 1'b0;
        if (state_nxt == REQ) begin
            wait_lamp_nxt = 1'b1;
        end else if (state_nxt == WALK || state_nxt == HOLDOFF) begin
            wait_lamp_nxt = pending_nxt;
        end
    end

endmodule

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Pedestrian-side front end for the crossing controller; the requester end of the ped_btn / ped_light interface.
- Synchronises and debounces the raw push-button pad, then raises and holds the ped_btn request until the controller grants WALK (ped_light GREEN).
- Drives the WAIT lamp and a WALK countdown display.
- Enforces a minimum car-green gap between pedestrian phases.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a button level change (>=1).
- WALK_CYCLES, 4, countdown start value shown on walk_count at WALK entry (>=1, < 2**CNT_W).
- MIN_GAP_CYCLES, 8, cycles the request is held off after a WALK phase ends (>=1).
- CNT_W, 4, width of walk_count and internal counters.

Ports:
- clk  in  1  system clock, all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- btn_raw  in  1  raw pad input; asynchronous, may bounce
- ped_light  in  3  pedestrian light from controller; RED=100, YELLOW=010, GREEN=001
- ped_btn  out  1  registered request level to controller
- wait_lamp  out  1  registered; lit while a request is outstanding or pending
- walk_count  out  CNT_W  registered WALK countdown; 0 outside WALK

Behaviour:
- Reset (reset low, asynchronous): all flops cleared; ped_btn=0, wait_lamp=0, walk_count=0, state=IDLE, pending=0; synchroniser, debounced level and debounce counter all 0. Deassertion is synchronous to clk.
- Synchroniser: btn_raw passes through two flops to produce btn_s.
- Debounce counter (cnt):
  - btn_s==btn_db: cnt<=0.
  - else if cnt==DEBOUNCE_CYCLES-1: btn_db<=btn_s, cnt<=0.
  - else cnt<=cnt+1.
- Press: one-cycle btn_db rising edge. Any btn_s pulse shorter than DEBOUNCE_CYCLES cycles produces no press.
- Press latency: take the first edge sampling btn_raw=1 as edge 0. The press is seen by the FSM at edge DEBOUNCE_CYCLES+2, and ped_btn is high after that edge (edge 6 at default).
- GREEN decode: ped_light==3'b001 exactly. Any other code, including illegal multi-hot, is not GREEN.
- FSM states (Moore outputs, registered):
  - IDLE: ped_btn=0, wait_lamp=0. Press -> REQ. GREEN here is ignored.
  - REQ: ped_btn=1, wait_lamp=1. Further presses ignored. On GREEN -> WALK and walk_count<=WALK_CYCLES.
  - WALK: ped_btn=0, wait_lamp=pending. walk_count decrements by 1 per cycle and saturates at 0. A press sets pending. When GREEN drops -> HOLDOFF, with gap<=MIN_GAP_CYCLES and walk_count<=0.
  - HOLDOFF: ped_btn=0, wait_lamp=pending. A press sets pending. gap decrements each cycle. When gap==1 at an edge: -> REQ and clear pending if pending, else -> IDLE.
- Simultaneous events:
  - Press and GREEN in IDLE: go to REQ; WALK follows next cycle if GREEN persists.
  - Press on the same edge HOLDOFF expires: counts as pending, so -> REQ.
- GREEN held continuously: the FSM stays in WALK with walk_count at 0. There is no timeout; the controller owns phase timing.
- Reset mid-WALK or mid-REQ: ped_btn drops immediately (asynchronously) and the request is lost. The user must press again.

Decomposition:
- Shared package ped_pkg:
  - light encodings LIGHT_RED/YELLOW/GREEN (3-bit), matching the controller's constants;
  - ped_state_t enum {IDLE, REQ, WALK, HOLDOFF}.
- One sub-module, btn_debounce: two-flop synchroniser plus debounce counter plus rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clk, reset, din, level, press.
- The FSM and counters stay in ped_request_ctrl.

Test Plan:
- Clean press: btn_raw=1 from edge 0, ped_light=100 -> ped_btn=1 and wait_lamp=1 after edge 6 and held; no change while ped_light stays RED for 50 cycles.
- Bounce reject: btn_raw pulses of 1, 2, 3 cycles separated by 1 low cycle -> ped_btn never rises. A 6-cycle-high pulse then produces exactly one request.
- Grant and countdown: in REQ, drive ped_light=001 -> next cycle ped_btn=0, wait_lamp=0, walk_count=4, then 3,2,1,0,0. ped_light=100 -> walk_count=0, HOLDOFF entered.
- Holdoff with pending: press during WALK -> wait_lamp=1 and ped_btn=0 throughout HOLDOFF. ped_btn reasserts exactly 8 cycles after GREEN drop. Without a press, returns to IDLE with ped_btn=0.
- Illegal light: in REQ, drive ped_light=011 then 101 -> stays REQ with ped_btn=1; 001 -> WALK.
- Async reset: assert reset low mid-REQ, between clock edges -> ped_btn, wait_lamp, walk_count go 0 immediately. After release with btn_raw still held high, a new request appears after 6 edges.
